// File: rtl/pc_fetch_ras_unit.sv
// Instruction-fetch unit: holds the PC, selects the next PC from sequential,
// jump, branch, call, indirect call or return, and keeps a circular hardware
// return-address stack so RET needs no register operand.
module pc_fetch_ras_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         SIG_Jump,
    input  logic                         SIG_Call,
    input  logic                         SIG_CALL_RS1,
    input  logic                         SIG_RET,
    input  logic                         SIG_BEQ,
    input  logic                         SIG_BNE,
    input  logic                         SIG_EQ,
    input  logic [XLEN-1:0]              jumpAddress,
    input  logic [XLEN-1:0]              branchAddress,
    input  logic [XLEN-1:0]              callRs1Address,
    input  logic [XLEN-1:0]              imem_data,
    output logic [XLEN-1:0]              imem_addr,
    output logic [XLEN-1:0]              instruction,
    output logic [XLEN-1:0]              PC4,
    output logic [XLEN-1:0]              pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         misalign
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    // Return-address storage; ras_ptr_reg always points at the next free
    // slot, so once the stack is full it also points at the oldest entry,
    // which is exactly the one a further push must overwrite.
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];

    logic [XLEN-1:0] pc_reg, pc_next;
    logic [PW-1:0]   ras_ptr_reg, ras_ptr_next;
    logic [CW-1:0]   ras_count_reg, ras_count_next;
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;
    logic            misalign_reg, misalign_next;

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   ras_wr_idx;
    logic            ras_wr_en;
    logic            ras_empty;
    logic            ras_full;
    logic            is_call;
    logic            branch_taken;

    assign pc4          = pc_reg + XLEN'(4);
    assign top_idx      = ras_ptr_reg - PW'(1);
    assign ras_top      = ras_mem[top_idx];
    assign ras_empty    = (ras_count_reg == '0);
    assign ras_full     = (ras_count_reg == CW'(RAS_DEPTH));
    assign is_call      = SIG_Call | SIG_CALL_RS1;
    assign branch_taken = (SIG_BEQ & SIG_EQ) | (SIG_BNE & ~SIG_EQ);

    assign imem_addr     = pc_reg;
    assign instruction   = imem_data;
    assign PC4           = pc4;
    assign pc            = pc_reg;
    assign ras_count     = ras_count_reg;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;
    assign misalign      = misalign_reg;

    // Next-PC selection, stack pointer/count update and flag generation.
    always_comb begin
        target         = pc4;
        pc_next        = pc_reg;
        ras_ptr_next   = ras_ptr_reg;
        ras_count_next = ras_count_reg;
        ras_wr_en      = 1'b0;
        ras_wr_idx     = ras_ptr_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        misalign_next  = 1'b0;

        if (!stall) begin
            if (SIG_RET) begin
                if (ras_empty) begin
                    target         = pc4;
                    underflow_next = 1'b1;
                end else begin
                    target = ras_top;
                end
            end else if (SIG_CALL_RS1) begin
                target = callRs1Address;
            end else if (SIG_Call || SIG_Jump) begin
                target = jumpAddress;
            end else if (branch_taken) begin
                target = branchAddress;
            end

            misalign_next = |target[1:0];
            pc_next       = {target[XLEN-1:2], 2'b00};

            if (SIG_RET && is_call) begin
                // Pop-then-push: the top is replaced in place, or on an empty
                // stack the return address becomes the single entry.
                ras_wr_en = 1'b1;
                if (ras_empty) begin
                    ras_wr_idx     = ras_ptr_reg;
                    ras_ptr_next   = ras_ptr_reg + PW'(1);
                    ras_count_next = CW'(1);
                end else begin
                    ras_wr_idx = top_idx;
                end
            end else if (SIG_RET) begin
                if (!ras_empty) begin
                    ras_ptr_next   = top_idx;
                    ras_count_next = ras_count_reg - CW'(1);
                end
            end else if (is_call) begin
                ras_wr_en    = 1'b1;
                ras_wr_idx   = ras_ptr_reg;
                ras_ptr_next = ras_ptr_reg + PW'(1);
                if (ras_full) begin
                    overflow_next = 1'b1;
                end else begin
                    ras_count_next = ras_count_reg + CW'(1);
                end
            end
        end
    end

    // PC, stack bookkeeping and one-cycle flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_PC;
            ras_ptr_reg   <= '0;
            ras_count_reg <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            ras_ptr_reg   <= ras_ptr_next;
            ras_count_reg <= ras_count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            misalign_reg  <= misalign_next;
        end
    end

    // Return-address write; contents need no reset since the count gates use.
    always_ff @(posedge clk) begin
        if (!reset && ras_wr_en) begin
            ras_mem[ras_wr_idx] <= pc4;
        end
    end

endmodule
